// File: rtl/wave_gen.sv
// DDS waveform generator: phase accumulator, four waveform shapes and
// power-of-two attenuation about mid-scale. Settings commit at period boundaries.
module wave_gen #(
  parameter int ACC_W   = 24,
  parameter int FREQ_W  = 16,
  parameter int OUT_W   = 14,
  parameter int PHASE_W = 8,
  parameter int AMP_W   = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [FREQ_W-1:0]  freq,
  input  logic [PHASE_W-1:0] phase,
  input  logic [AMP_W-1:0]   amp,
  input  logic [1:0]         mode,
  input  logic               load,
  output logic               pending,
  output logic               sync,
  output logic [OUT_W-1:0]   DAC_in
);

  localparam logic [OUT_W-1:0] MID = {1'b1, {(OUT_W-1){1'b0}}};

  // Stage 0 state and settings
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic               wrap_q, wrap_d;
  logic [FREQ_W-1:0]  act_freq_q, act_freq_d, sh_freq_q, sh_freq_d;
  logic [PHASE_W-1:0] act_phase_q, act_phase_d, sh_phase_q, sh_phase_d;
  logic [AMP_W-1:0]   act_amp_q, act_amp_d, sh_amp_q, sh_amp_d;
  logic [1:0]         act_mode_q, act_mode_d, sh_mode_q, sh_mode_d;
  logic               pending_q, pending_d;

  // Stage 1 / stage 2
  logic [OUT_W-1:0]   w_q, w_d;
  logic [AMP_W-1:0]   amp1_q, amp1_d;
  logic               sync1_q, sync1_d;
  logic [OUT_W-1:0]   dac_q, dac_d;
  logic               sync_q, sync_d;

  logic [ACC_W:0]     sum;
  logic               commit;
  logic [OUT_W-1:0]   phase_ext, p, p2, wave;
  logic signed [OUT_W:0] dev, dev_sh;
  logic [OUT_W:0]     dac_sum;

  always_comb begin
    sum    = {1'b0, acc_q} + {{(ACC_W+1-FREQ_W){1'b0}}, act_freq_q};
    wrap_d = en & sum[ACC_W];
    acc_d  = en ? sum[ACC_W-1:0] : '0;

    // A loaded value arriving on a commit cycle bypasses the shadow
    commit = !en || (act_freq_q == '0) || wrap_d;

    sh_freq_d  = load ? freq  : sh_freq_q;
    sh_phase_d = load ? phase : sh_phase_q;
    sh_amp_d   = load ? amp   : sh_amp_q;
    sh_mode_d  = load ? mode  : sh_mode_q;

    act_freq_d  = commit ? sh_freq_d  : act_freq_q;
    act_phase_d = commit ? sh_phase_d : act_phase_q;
    act_amp_d   = commit ? sh_amp_d   : act_amp_q;
    act_mode_d  = commit ? sh_mode_d  : act_mode_q;

    pending_d = commit ? 1'b0 : (load ? 1'b1 : pending_q);
  end

  always_comb begin
    phase_ext = '0;
    phase_ext[OUT_W-1 -: PHASE_W] = act_phase_q;
    p  = acc_q[ACC_W-1 -: OUT_W] + phase_ext;
    p2 = {p[OUT_W-2:0], 1'b0};
    case (act_mode_q)
      2'd0:    wave = p;
      2'd1:    wave = ~p;
      2'd2:    wave = p[OUT_W-1] ? ~p2 : p2;
      default: wave = p[OUT_W-1] ? {OUT_W{1'b1}} : '0;
    endcase
    // A zero step is treated as stopped: hold the output at mid-scale
    w_d     = (en && act_freq_q != '0) ? wave : MID;
    amp1_d  = act_amp_q;
    sync1_d = en & wrap_q;
  end

  always_comb begin
    dev     = $signed({1'b0, w_q}) - $signed({1'b0, MID});
    dev_sh  = dev >>> amp1_q;
    dac_sum = {1'b0, MID} + $unsigned(dev_sh);
    dac_d   = en ? dac_sum[OUT_W-1:0] : MID;
    sync_d  = en & sync1_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q       <= '0;
      wrap_q      <= 1'b0;
      act_freq_q  <= '0;
      act_phase_q <= '0;
      act_amp_q   <= '0;
      act_mode_q  <= '0;
      sh_freq_q   <= '0;
      sh_phase_q  <= '0;
      sh_amp_q    <= '0;
      sh_mode_q   <= '0;
      pending_q   <= 1'b0;
      w_q         <= MID;
      amp1_q      <= '0;
      sync1_q     <= 1'b0;
      dac_q       <= MID;
      sync_q      <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      wrap_q      <= wrap_d;
      act_freq_q  <= act_freq_d;
      act_phase_q <= act_phase_d;
      act_amp_q   <= act_amp_d;
      act_mode_q  <= act_mode_d;
      sh_freq_q   <= sh_freq_d;
      sh_phase_q  <= sh_phase_d;
      sh_amp_q    <= sh_amp_d;
      sh_mode_q   <= sh_mode_d;
      pending_q   <= pending_d;
      w_q         <= w_d;
      amp1_q      <= amp1_d;
      sync1_q     <= sync1_d;
      dac_q       <= dac_d;
      sync_q      <= sync_d;
    end
  end

  assign pending = pending_q;
  assign sync    = sync_q;
  assign DAC_in  = dac_q;

endmodule

// File: tb/tb_wave_gen.sv
// Directed bench for wave_gen: reset, waveforms, attenuation, deferred commit, reset mid-run.
module tb_wave_gen;

  logic        clk = 1'b0;
  logic        rst, en, load, pending, sync;
  logic [15:0] freq;
  logic [7:0]  phase;
  logic [2:0]  amp;
  logic [1:0]  mode;
  logic [13:0] DAC_in;

  int n_pass  = 0;
  int n_total = 0;
  int k;

  always #5 clk = ~clk;

  wave_gen dut (
    .clk(clk), .rst(rst), .en(en), .freq(freq), .phase(phase), .amp(amp),
    .mode(mode), .load(load), .pending(pending), .sync(sync), .DAC_in(DAC_in)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic restart(input logic [15:0] f, input logic [7:0] ph,
                         input logic [2:0] a, input logic [1:0] m);
    en = 1'b0; load = 1'b1; freq = f; phase = ph; amp = a; mode = m;
    tick();
    load = 1'b0; en = 1'b1;
    tick();
    tick();
    k = 0;
    $display("restart freq=%h phase=%h amp=%0d mode=%0d -> DAC_in=%0d", f, ph, a, m, DAC_in);
  endtask

  task automatic adv(input int n);
    repeat (n) tick();
    k += n;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; load = 1'b0;
    freq = '0; phase = '0; amp = '0; mode = '0;

    // Reset and idle
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_dac", DAC_in, 8192);
      chk("rst_sync", sync, 0);
      chk("rst_pending", pending, 0);
    end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("idle_dac", DAC_in, 8192);
      chk("idle_sync", sync, 0);
      chk("idle_pending", pending, 0);
    end
    $display("step reset/idle: DAC_in=%0d", DAC_in);

    // Saw up: load while disabled commits immediately
    load = 1'b1; freq = 16'h4000; mode = 2'd0; amp = 3'd0; phase = 8'h00;
    tick();
    chk("load_en0_pending", pending, 0);
    load = 1'b0; en = 1'b1;
    tick();
    chk("saw_latency", DAC_in, 8192);
    tick();
    chk("saw_first", DAC_in, 0);
    chk("saw_first_sync", sync, 0);
    for (int i = 1; i <= 1030; i++) begin
      tick();
      chk("saw_up", DAC_in, (16 * i) % 16384);
      chk("saw_sync", sync, (i % 1024 == 0) ? 1 : 0);
    end
    $display("step saw up: DAC_in=%0d sync=%0d", DAC_in, sync);

    // Square, amp=1 and amp=7
    restart(16'h4000, 8'h00, 3'd1, 2'd3);
    chk("sq1_0", DAC_in, 4096);
    adv(511); chk("sq1_511", DAC_in, 4096);
    adv(1);   chk("sq1_512", DAC_in, 12287);
    adv(511); chk("sq1_1023", DAC_in, 12287);
    adv(1);   chk("sq1_1024", DAC_in, 4096);
    chk("sq1_sync", sync, 1);
    restart(16'h4000, 8'h00, 3'd7, 2'd3);
    chk("sq7_lo", DAC_in, 8128);
    adv(512); chk("sq7_hi", DAC_in, 8255);

    // Triangle with phase offset, then saw down
    restart(16'h4000, 8'h40, 3'd0, 2'd2);
    chk("tri_0", DAC_in, 8192);
    adv(1);   chk("tri_1", DAC_in, 8224);
    adv(254); chk("tri_peak_rise", DAC_in, 16352);
    adv(1);   chk("tri_top", DAC_in, 16383);
    adv(1);   chk("tri_fall", DAC_in, 16351);
    restart(16'h4000, 8'h00, 3'd0, 2'd1);
    chk("sawdn_0", DAC_in, 16383);
    adv(1);   chk("sawdn_1", DAC_in, 16367);

    // Deferred commit mid-period, then load exactly on the wrap cycle
    restart(16'h4000, 8'h00, 3'd0, 2'd0);
    for (int i = 1; i <= 1540; i++) begin
      if (i == 101) begin
        load = 1'b1; freq = 16'h8000;
      end else if (i == 1534) begin
        load = 1'b1; freq = 16'h4000;
      end
      tick();
      load = 1'b0;
      k = i;
      chk("defer_pending", pending, (i >= 101 && i < 1022) ? 1 : 0);
      if (i < 1024)      chk("defer_dac_a", DAC_in, (16 * i) % 16384);
      else if (i < 1536) chk("defer_dac_b", DAC_in, (32 * (i - 1024)) % 16384);
      else               chk("defer_dac_c", DAC_in, (16 * (i - 1536)) % 16384);
      chk("defer_sync", sync, (i == 1024 || i == 1536) ? 1 : 0);
      if (i == 101 || i == 1022 || i == 1534 || i == 1537)
        $display("step defer k=%0d: DAC_in=%0d pending=%0d", i, DAC_in, pending);
    end

    // Reset while a setting is pending
    load = 1'b1; freq = 16'h8000;
    tick();
    load = 1'b0;
    chk("pre_rst_pending", pending, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_run_dac", DAC_in, 8192);
    chk("rst_run_pending", pending, 0);
    chk("rst_run_sync", sync, 0);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("post_rst_dac", DAC_in, 8192);
      chk("post_rst_pending", pending, 0);
    end
    $display("step reset mid-run: DAC_in=%0d pending=%0d", DAC_in, pending);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
